// File: rtl/mem_read_return_buffer.sv
// Read return buffer: issues reads to a fixed-latency RAM and parks the returns in a credit-reserved FIFO.
// Optional macro MEM_READ_RETURN_BYPASS_EN presents a return directly when the FIFO is empty.
module mem_read_return_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    parameter int DEPTH        = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  addr_in_valid,
    output logic                  addr_in_ack,
    input  logic [ADDR_WIDTH-1:0] addr_in_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  data_out_valid,
    input  logic                  data_out_ack,
    output logic [DATA_WIDTH-1:0] data_out_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("mem_read_return_buffer: READ_LATENCY must be >= 1");
    end
    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < READ_LATENCY + 1)) begin : g_bad_depth
        $error("mem_read_return_buffer: DEPTH must be a power of two and >= READ_LATENCY+1");
    end

    logic [DATA_WIDTH-1:0]   fifo [DEPTH];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           count, inflight;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [CW:0]             reserved;
    logic                    ret, deq, push, pop, fifo_valid;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            inflight = inflight + CW'(vld_pipe[i]);
    end

    // A slot is reserved at issue time, so a return always finds room in the FIFO.
    assign reserved    = {1'b0, count} + {1'b0, inflight};
    assign deq         = data_out_valid && data_out_ack;
    assign addr_in_ack = reset_n && ((reserved - (CW+1)'(deq)) < (CW+1)'(DEPTH));
    assign mem_read_en = addr_in_valid && addr_in_ack;
    assign mem_addr    = mem_read_en ? addr_in_data : '0;

    assign ret        = vld_pipe[READ_LATENCY-1];
    assign fifo_valid = reset_n && (count != '0);

`ifdef MEM_READ_RETURN_BYPASS_EN
    logic byp;
    // An acked bypass word never touches the FIFO; an unacked one is parked as usual.
    assign byp            = reset_n && ret && (count == '0);
    assign data_out_valid = fifo_valid || byp;
    assign data_out_data  = fifo_valid ? fifo[rd_ptr] : (byp ? mem_rdata : '0);
    assign push           = ret && !(byp && data_out_ack);
    assign pop            = deq && fifo_valid;
`else
    assign data_out_valid = fifo_valid;
    assign data_out_data  = fifo_valid ? fifo[rd_ptr] : '0;
    assign push           = ret;
    assign pop            = deq;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            vld_pipe[0] <= mem_read_en;
            for (int i = 1; i < READ_LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && push)
            fifo[wr_ptr] <= mem_rdata;
    end

endmodule

// File: tb/tb_mem_read_return_buffer.sv
// Scoreboard bench for mem_read_return_buffer: directed stimulus pushes expected words, a monitor pops on each transfer.
module tb_mem_read_return_buffer;
    localparam int DW = 32, AW = 16, RL = 2, DEPTH = 4;
`ifdef MEM_READ_RETURN_BYPASS_EN
    localparam int LAT = RL;
`else
    localparam int LAT = RL + 1;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          addr_in_valid, addr_in_ack;
    logic [AW-1:0] addr_in_data, mem_addr;
    logic          mem_read_en;
    logic [DW-1:0] mem_rdata;
    logic          data_out_valid, data_out_ack;
    logic [DW-1:0] data_out_data;

    always #5 clock = ~clock;

    mem_read_return_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .addr_in_valid(addr_in_valid), .addr_in_ack(addr_in_ack), .addr_in_data(addr_in_data),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_rdata(mem_rdata),
        .data_out_valid(data_out_valid), .data_out_ack(data_out_ack), .data_out_data(data_out_data)
    );

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {16'hA5A5, a};
    endfunction

    // RAM model: data valid RL cycles after the strobe edge; junk otherwise.
    logic [DW-1:0] ram_pipe [RL];
    always @(posedge clock) begin
        ram_pipe[0] <= mem_read_en ? ram_word(mem_addr) : 32'hBAD0BAD0;
        for (int i = 1; i < RL; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign mem_rdata = ram_pipe[RL-1];

    int            tests = 0, fails = 0;
    int            cyc = 0, pop_cnt = 0, last_pop = 0;
    logic [DW-1:0] exp_q [$];

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && data_out_valid && data_out_ack) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %0h expected no output", data_out_data);
            end else begin
                check("out_data", data_out_data, exp_q.pop_front());
                pop_cnt++;
                last_pop = cyc;
            end
        end
    end

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, acc, en, p0, n, bad;
        logic [AW-1:0] a;
        reset_n = 1'b0; addr_in_valid = 1'b1; addr_in_data = 16'h0055; data_out_ack = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_addr_ack", addr_in_ack, 0);
        check("rst_read_en", mem_read_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_out_valid", data_out_valid, 0);
        check("rst_out_data", data_out_data, 0);
        @(posedge clock); #1 reset_n = 1'b1; addr_in_valid = 1'b0; addr_in_data = '0;

        // single read, held under backpressure
        @(posedge clock); #1 addr_in_valid = 1'b1; addr_in_data = 16'h0010;
        @(negedge clock);
        check("single_ack", addr_in_ack, 1);
        check("single_read_en", mem_read_en, 1);
        check("single_mem_addr", mem_addr, 16'h0010);
        exp_q.push_back(32'hDEADBEEF);
        t0 = cyc;
        @(posedge clock); #1 addr_in_valid = 1'b0;
        do @(negedge clock); while (!data_out_valid && (cyc - t0) < 20);
        check("single_latency", cyc - t0, LAT);
        repeat (3) begin
            @(negedge clock);
            check("single_hold_valid", data_out_valid, 1);
            check("single_hold_data", data_out_data, 32'hDEADBEEF);
        end
        @(posedge clock); #1 data_out_ack = 1'b1;
        @(posedge clock); #1 data_out_ack = 1'b0;
        @(negedge clock);
        check("single_empty_after", data_out_valid, 0);
        check("single_popped", exp_q.size(), 0);

        // streaming 0..15 with the sink always ready
        @(posedge clock); #1 data_out_ack = 1'b1;
        acc = 0; en = 0; p0 = pop_cnt; t0 = 0;
        for (int i = 0; i < 16; i++) begin
            addr_in_valid = 1'b1; addr_in_data = AW'(i);
            @(negedge clock);
            if (i == 0) t0 = cyc;
            if (addr_in_ack) begin acc++; exp_q.push_back(ram_word(AW'(i))); end
            if (mem_read_en && mem_addr == AW'(i)) en++;
            @(posedge clock); #1;
        end
        addr_in_valid = 1'b0;
        drain("stream");
        check("stream_accepted", acc, 16);
        check("stream_read_en", en, 16);
        check("stream_pops", pop_cnt - p0, 16);
        check("stream_last_pop", last_pop - t0, 15 + LAT);

        // backpressure: only DEPTH reads fit while the sink stalls
        @(posedge clock); #1 data_out_ack = 1'b0;
        acc = 0; a = 16'h0020;
        for (int i = 0; i < 8; i++) begin
            addr_in_valid = 1'b1; addr_in_data = a;
            @(negedge clock);
            if (addr_in_ack) begin exp_q.push_back(ram_word(a)); a++; acc++; end
            @(posedge clock); #1;
        end
        check("bp_accepted", acc, 4);
        @(negedge clock);
        check("bp_ack_blocked", addr_in_ack, 0);
        check("bp_count_full", dut.count, 4);
        @(posedge clock); #1 data_out_ack = 1'b1;
        @(negedge clock);
        check("bp_ack_on_deq", addr_in_ack, 1);
        check("bp_valid_on_deq", data_out_valid, 1);
        if (addr_in_ack) begin exp_q.push_back(ram_word(a)); a++; end
        for (int i = 0; i < 20 && a < 16'h0028; i++) begin
            @(posedge clock); #1 addr_in_data = a;
            @(negedge clock);
            if (addr_in_ack) begin exp_q.push_back(ram_word(a)); a++; end
        end
        @(posedge clock); #1 addr_in_valid = 1'b0;
        drain("bp");

        // count = 3 with one read in flight; return and dequeue in the same cycle
        @(posedge clock); #1 data_out_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr_in_valid = 1'b1; addr_in_data = AW'(16'h0030 + i);
            @(negedge clock);
            check("full_issue_ack", addr_in_ack, 1);
            exp_q.push_back(ram_word(AW'(16'h0030 + i)));
            @(posedge clock); #1;
        end
        addr_in_valid = 1'b0;
        @(posedge clock); #1 data_out_ack = 1'b1;
        @(negedge clock);
        check("full_pre_count", dut.count, 3);
        check("full_pre_valid", data_out_valid, 1);
        @(posedge clock); #1 data_out_ack = 1'b0;
        @(negedge clock);
        check("full_post_count", dut.count, 3);
        @(posedge clock); #1 data_out_ack = 1'b1;
        drain("full");

        // reset while two reads are in flight
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1 addr_in_valid = 1'b1; addr_in_data = AW'(16'h0050 + i);
            @(negedge clock);
            check("rstmid_issue_ack", addr_in_ack, 1);
        end
        @(posedge clock); #1 addr_in_valid = 1'b0; reset_n = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clock);
            if (data_out_valid) bad++;
        end
        check("rstmid_no_valid", bad, 0);
        check("rstmid_count", dut.count, 0);

        // first-word latency from an empty FIFO with the sink ready
        @(posedge clock); #1 addr_in_valid = 1'b1; addr_in_data = 16'h0040;
        @(negedge clock);
        check("lat_ack", addr_in_ack, 1);
        exp_q.push_back(ram_word(16'h0040));
        t0 = cyc;
        @(posedge clock); #1 addr_in_valid = 1'b0;
        n = 0;
        do @(negedge clock); while (!data_out_valid && (cyc - t0) < 20);
        check("lat_first_valid", cyc - t0, LAT);
        check("lat_data", data_out_data, 32'hA5A50040);
        @(negedge clock);
        check("lat_count_after", dut.count, 0);
        drain("lat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_read_return_buffer.md
Name: mem_read_return_buffer

Overview:
- Read-side counterpart of the write buffer that feeds the delayed RAM.
- Accepts read addresses on a pipeline consumer interface and issues them to a RAM with fixed read latency.
- Captures the returned words in a small FIFO and delivers them on a pipeline producer interface.
- Credit accounting reserves a FIFO slot before each read is issued, so returned data is never dropped and the RAM needs no stall input.

Parameters:
- DATA_WIDTH, 32: RAM word width and width of data_out.data.
- ADDR_WIDTH, 16: RAM address width and width of addr_in.data.
- READ_LATENCY, 2: cycles from the mem_read_en edge to mem_rdata being valid. Legal range ≥1.
- DEPTH, 4: return FIFO entries. Must be a power of two and ≥ READ_LATENCY+1; elaboration error otherwise.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- addr_in  data_interface.consumer  ADDR_WIDTH  read addresses. Transfer = valid && ack in the same cycle.
- mem_addr  output  ADDR_WIDTH  RAM read address.
- mem_read_en  output  1  RAM read strobe, one read per high cycle.
- mem_rdata  input  DATA_WIDTH  RAM read data, valid READ_LATENCY cycles after its strobe.
- data_out  data_interface.producer  DATA_WIDTH  read results in request order. Transfer = valid && ack.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-low on reset_n, sampled at the rising edge of clock.
- Reset state:
  - FIFO empty; rd_ptr = wr_ptr = 0; count = 0.
  - In-flight shift register cleared.
  - While reset_n = 0: addr_in.ack = 0, mem_read_en = 0, data_out.valid = 0, data_out.data = 0, mem_addr = 0.
- Credits: reserved = count + inflight, where inflight = number of set bits in the READ_LATENCY-deep valid shift register. Width $clog2(DEPTH+1).
- Accept rule: addr_in.ack = reset_n && (reserved - deq < DEPTH), where deq = data_out.valid && data_out.ack. A same-cycle dequeue frees a credit combinationally.
- Issue:
  - Combinational: mem_read_en = addr_in.valid && addr_in.ack; mem_addr = addr_in.data when issuing, 0 otherwise.
  - Registered: the strobe bit enters shift stage 0.
- Return: when the shift register's last stage is 1, mem_rdata is written at wr_ptr and wr_ptr increments. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Output:
  - data_out.valid = (count != 0); data_out.data = fifo[rd_ptr], or 0 when empty.
  - On deq, rd_ptr increments.
  - Data stays stable while valid && !ack.
- Latency: address accepted at cycle t → data_out.valid at t+READ_LATENCY+1.
- Throughput: one read per cycle sustained when data_out.ack is held high.
- Ordering: strict FIFO, request order.
- Simultaneous return and dequeue: both happen; count is unchanged. This also holds when count = DEPTH-1 or when full.
- Full (reserved = DEPTH with no deq): addr_in.ack = 0, mem_read_en = 0. No overflow is possible by construction.
- Empty: data_out.valid = 0; deq is ignored.
- Reset mid-operation: in-flight bits are cleared, so words the RAM returns after reset deasserts are ignored. FIFO contents are discarded.
- Never: count > DEPTH; a return while count = DEPTH without a same-cycle deq.

Optional Feature:
- Macro: MEM_READ_RETURN_BYPASS_EN.
- Defined:
  - When count = 0 and a return arrives, the return is presented directly: data_out.valid = 1, data_out.data = mem_rdata in that cycle.
  - If data_out.ack = 1 that cycle, the word is consumed and not written to the FIFO; otherwise it is written.
  - Latency becomes READ_LATENCY. Creates a combinational path mem_rdata → data_out.data.
- Undefined: no bypass. Behaviour is exactly as above, with latency READ_LATENCY+1.

Test Plan:
- Single read: reset, then addr_in = 0x0010 for one cycle, RAM model returns 0xDEADBEEF. Expect mem_read_en at cycle 1, data_out.valid at cycle 4 (READ_LATENCY = 2) with 0xDEADBEEF, held until ack.
- Streaming: addresses 0..15 back-to-back with data_out.ack = 1. Expect mem_read_en high 16 consecutive cycles and 16 outputs in order, one per cycle, with no addr_in.ack gap.
- Backpressure:
  - data_out.ack = 0 while 8 addresses are offered. Expect exactly 4 accepted (DEPTH = 4), then addr_in.ack = 0 and count = 4.
  - Raise data_out.ack. Expect the first address accepted in the same cycle as the first dequeue.
- Full simultaneous: count = 3, one read in flight, one return and one dequeue in the same cycle. Expect count stays 3 and the data order is preserved.
- Reset mid-flight: two reads issued, reset_n = 0 for 1 cycle before the returns. Expect data_out.valid = 0 afterwards and the late RAM words ignored.
- Bypass (macro defined): empty FIFO, single read. Expect data_out.valid at cycle 3 with mem_rdata, and count stays 0 when acked.
